draw_regctrl_fifo_buf: RTL and testbench

//  Parametrised command buffer between the register-control decoder and the draw engine.

---
 rtl/draw_regctrl_fifo_buf_pkg.sv | 21 ++
 rtl/draw_regctrl_fifo_buf_if.sv | 34 +++
 rtl/draw_regctrl_fifo_buf_ram.sv | 39 +++
 rtl/draw_regctrl_fifo_buf.sv | 144 ++++++++++++++
 tb/tb_draw_regctrl_fifo_buf.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_regctrl_fifo_buf_pkg.sv
// Shared constants for the draw command buffer: error bit positions, default widths
// and the read-mode encoding.
package draw_regctrl_fifo_buf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;

    localparam int ERR_OVF = 1;
    localparam int ERR_UDF = 0;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Thresholds are compared against a count that spans 0..2**addr_w inclusive.
    function automatic logic thr_in_range(input int th, input int addr_w);
        return (th >= 0) && (th <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/draw_regctrl_fifo_buf_if.sv
// Command-buffer bus between the register-control decoder (master) and the buffer (slave).
interface draw_regctrl_fifo_buf_if
    import draw_regctrl_fifo_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              init;
    logic [DATA_W-1:0] indata;
    logic              buf_wr;
    logic              buf_rd;
    logic              err_clr;

    logic [DATA_W-1:0] outdata;
    logic              datavalid;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic [ADDR_W:0]   wcount;
    logic [1:0]        err_buf;

    modport master (
        output init, indata, buf_wr, buf_rd, err_clr,
        input  outdata, datavalid, full, empty, afull, aempty, wcount, err_buf
    );

    modport slave (
        input  init, indata, buf_wr, buf_rd, err_clr,
        output outdata, datavalid, full, empty, afull, aempty, wcount, err_buf
    );

endinterface

// File: rtl/draw_regctrl_fifo_buf_ram.sv
// Simple dual-port storage for the command buffer: synchronous write, registered read
// with read enable. The read register doubles as the buffer output register.
module draw_regctrl_fifo_buf_ram
    import draw_regctrl_fifo_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Contents are never reset; only the read register is, so OUTDATA starts at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/draw_regctrl_fifo_buf.sv
// Parametrised command buffer between the register-control decoder and the draw engine:
// pointers, word count, threshold flags, sticky errors and optional first-word-fall-through.
module draw_regctrl_fifo_buf
    import draw_regctrl_fifo_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = 1008,
    parameter int AEMPTY_TH = 16,
    parameter int FWFT      = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    draw_regctrl_fifo_buf_if.slave  io_bus
);

    localparam rd_mode_e          LP_MODE      = (FWFT != 0) ? RD_FWFT : RD_STD;
    localparam logic [ADDR_W:0]   LP_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LP_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LP_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LP_AFULL_TH  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   LP_AEMPTY_TH = (ADDR_W+1)'(AEMPTY_TH);

    if (!thr_in_range(AFULL_TH, ADDR_W)) begin : g_chk_afull
        $error("draw_regctrl_fifo_buf: AFULL_TH outside 0..2**ADDR_W");
    end
    if (!thr_in_range(AEMPTY_TH, ADDR_W)) begin : g_chk_aempty
        $error("draw_regctrl_fifo_buf: AEMPTY_TH outside 0..2**ADDR_W");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_wcount;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_dv;
    logic [1:0]        r_err;

    logic              w_run;
    logic              w_rd_ok;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ovf;
    logic              w_udf;
    logic              w_ram_has;
    logic              w_pref;
    logic              w_ram_rd;
    logic [ADDR_W:0]   w_wcount_nxt;
    logic [DATA_W-1:0] w_rd_data;

    assign w_run    = ~i_rst & ~io_bus.init;

    // In FWFT mode a read is an acknowledge of the word already presented on OUTDATA.
    assign w_rd_ok  = (LP_MODE == RD_FWFT) ? r_dv : ~r_empty;

    assign w_wr_acc = w_run & io_bus.buf_wr & ~r_full;
    assign w_rd_acc = w_run & io_bus.buf_rd & w_rd_ok;
    assign w_ovf    = w_run & io_bus.buf_wr & r_full;
    assign w_udf    = w_run & io_bus.buf_rd & ~w_rd_ok;

    // WCOUNT includes the presented word, so stored-but-unfetched words exist iff count != dv.
    assign w_ram_has = (r_wcount != {{ADDR_W{1'b0}}, r_dv});
    assign w_pref    = w_run & w_ram_has & (~r_dv | w_rd_acc);
    assign w_ram_rd  = (LP_MODE == RD_FWFT) ? w_pref : w_rd_acc;

    always_comb begin
        w_wcount_nxt = r_wcount;
        if (w_wr_acc && !w_rd_acc) begin
            w_wcount_nxt = r_wcount + LP_CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_wcount_nxt = r_wcount - LP_CNT_ONE;
        end
    end

    draw_regctrl_fifo_buf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (io_bus.indata),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wcount <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_dv     <= 1'b0;
            r_err    <= 2'b00;
        end else if (io_bus.init) begin
            // Flush: same as reset except the error history survives.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wcount <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_dv     <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            r_wcount <= w_wcount_nxt;
            r_full   <= (w_wcount_nxt == LP_DEPTH);
            r_empty  <= (w_wcount_nxt == '0);
            r_afull  <= (w_wcount_nxt >= LP_AFULL_TH);
            r_aempty <= (w_wcount_nxt <= LP_AEMPTY_TH);
            if (LP_MODE == RD_FWFT) begin
                r_dv <= w_pref | (r_dv & ~w_rd_acc);
            end else begin
                r_dv <= w_rd_acc;
            end
            // A fresh error in the clear cycle keeps the flag set.
            r_err[ERR_OVF] <= w_ovf | (r_err[ERR_OVF] & ~io_bus.err_clr);
            r_err[ERR_UDF] <= w_udf | (r_err[ERR_UDF] & ~io_bus.err_clr);
        end
    end

    assign io_bus.outdata   = w_rd_data;
    assign io_bus.datavalid = r_dv;
    assign io_bus.full      = r_full;
    assign io_bus.empty     = r_empty;
    assign io_bus.afull     = r_afull;
    assign io_bus.aempty    = r_aempty;
    assign io_bus.wcount    = r_wcount;
    assign io_bus.err_buf   = r_err;

endmodule

// File: tb/tb_draw_regctrl_fifo_buf.sv
// Scoreboard bench for the command buffer: one standard-read and one FWFT instance
// driven side by side against a behavioural model.
module tb_draw_regctrl_fifo_buf;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int AF    = 1008;
    localparam int AE    = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    draw_regctrl_fifo_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    draw_regctrl_fifo_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    draw_regctrl_fifo_buf #(
        .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)
    ) u_dut_std (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_a.slave)
    );

    draw_regctrl_fifo_buf #(
        .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)
    ) u_dut_fwft (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_b.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    int          m_cnt_a, m_cnt_b;
    logic [1:0]  m_err_a, m_err_b;
    logic        m_dv_a,  m_dv_b;
    logic [31:0] mdl_a[$], mdl_b[$];
    logic [31:0] sb_a[$],  sb_b[$];
    logic [31:0] saved;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Standard mode: every DATAVALID pulse delivers the next expected word.
    always @(negedge clk) begin
        if (bus_a.datavalid === 1'b1) begin
            if (sb_a.size() == 0) check_val("a_spurious_dv", 1, 0);
            else                  check_val("a_data", bus_a.outdata, sb_a.pop_front());
        end
    end

    // FWFT mode: the word is consumed when the bench acknowledges a valid output.
    always @(negedge clk) begin
        if (bus_b.buf_rd && bus_b.datavalid === 1'b1 && !bus_b.init && !rst) begin
            if (sb_b.size() == 0) check_val("b_spurious_ack", 1, 0);
            else                  check_val("b_data", bus_b.outdata, sb_b.pop_front());
        end
    end

    task automatic clear_inputs();
        bus_a.init = 0; bus_a.buf_wr = 0; bus_a.buf_rd = 0; bus_a.err_clr = 0; bus_a.indata = '0;
        bus_b.init = 0; bus_b.buf_wr = 0; bus_b.buf_rd = 0; bus_b.err_clr = 0; bus_b.indata = '0;
    endtask

    // Advance one clock: update the model from the driven inputs, then check every output.
    task automatic step();
        logic wr_ok, rd_ok;
        if (rst) begin
            m_cnt_a = 0; m_err_a = 0; m_dv_a = 0; mdl_a.delete();
            m_cnt_b = 0; m_err_b = 0; m_dv_b = 0; mdl_b.delete();
        end else begin
            if (bus_a.init) begin
                m_cnt_a = 0; m_dv_a = 0; mdl_a.delete();
            end else begin
                wr_ok = bus_a.buf_wr && (m_cnt_a != DEPTH);
                rd_ok = bus_a.buf_rd && (m_cnt_a != 0);
                m_err_a[1] = (bus_a.buf_wr && m_cnt_a == DEPTH) || (m_err_a[1] && !bus_a.err_clr);
                m_err_a[0] = (bus_a.buf_rd && m_cnt_a == 0) || (m_err_a[0] && !bus_a.err_clr);
                if (rd_ok) sb_a.push_back(mdl_a.pop_front());
                if (wr_ok) mdl_a.push_back(bus_a.indata);
                m_cnt_a += int'(wr_ok) - int'(rd_ok);
                m_dv_a = rd_ok;
            end
            if (bus_b.init) begin
                m_cnt_b = 0; m_dv_b = 0; mdl_b.delete();
            end else begin
                wr_ok = bus_b.buf_wr && (m_cnt_b != DEPTH);
                rd_ok = bus_b.buf_rd && m_dv_b;
                m_err_b[1] = (bus_b.buf_wr && m_cnt_b == DEPTH) || (m_err_b[1] && !bus_b.err_clr);
                m_err_b[0] = (bus_b.buf_rd && !m_dv_b) || (m_err_b[0] && !bus_b.err_clr);
                if (rd_ok) sb_b.push_back(mdl_b.pop_front());
                // A word is presented next cycle iff one was already held before this cycle's writes.
                m_dv_b = (m_cnt_b - int'(rd_ok)) != 0;
                if (wr_ok) mdl_b.push_back(bus_b.indata);
                m_cnt_b += int'(wr_ok) - int'(rd_ok);
            end
        end
        @(posedge clk);
        #1;
        check_val("a_wcount", bus_a.wcount, m_cnt_a);
        check_val("a_full",   bus_a.full,   m_cnt_a == DEPTH);
        check_val("a_empty",  bus_a.empty,  m_cnt_a == 0);
        check_val("a_afull",  bus_a.afull,  m_cnt_a >= AF);
        check_val("a_aempty", bus_a.aempty, m_cnt_a <= AE);
        check_val("a_err",    bus_a.err_buf, m_err_a);
        check_val("a_dv",     bus_a.datavalid, m_dv_a);
        check_val("b_wcount", bus_b.wcount, m_cnt_b);
        check_val("b_full",   bus_b.full,   m_cnt_b == DEPTH);
        check_val("b_empty",  bus_b.empty,  m_cnt_b == 0);
        check_val("b_afull",  bus_b.afull,  m_cnt_b >= AF);
        check_val("b_aempty", bus_b.aempty, m_cnt_b <= AE);
        check_val("b_err",    bus_b.err_buf, m_err_b);
        check_val("b_dv",     bus_b.datavalid, m_dv_b);
        if (m_dv_b && mdl_b.size() != 0) check_val("b_head", bus_b.outdata, mdl_b[0]);
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset();
        check_val("rst_outdata_a", bus_a.outdata, 0);
        check_val("rst_outdata_b", bus_b.outdata, 0);

        // Four writes then four reads in standard mode.
        for (int i = 0; i < 4; i++) begin
            bus_a.buf_wr = 1; bus_a.indata = 32'h11 + i; step();
        end
        check_val("t1_wcount4", bus_a.wcount, 4);
        for (int i = 0; i < 4; i++) begin
            bus_a.buf_rd = 1; step();
        end
        step();
        check_val("t1_empty", bus_a.empty, 1);

        // Fill to capacity, overflow once, clear, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            bus_a.buf_wr = 1; bus_a.indata = 32'h1000 + i; step();
        end
        check_val("t2_full", bus_a.full, 1);
        bus_a.buf_wr = 1; bus_a.indata = 32'hDEAD; step();
        check_val("t2_ovf", bus_a.err_buf, 2'b10);
        check_val("t2_wcount", bus_a.wcount, DEPTH);
        bus_a.err_clr = 1; step();
        check_val("t2_clr", bus_a.err_buf, 2'b00);
        for (int i = 0; i < DEPTH; i++) begin
            bus_a.buf_rd = 1; step();
        end
        step();

        // Read on empty after reset, then clear racing a new underflow.
        do_reset();
        bus_a.buf_rd = 1; step();
        check_val("t3_udf", bus_a.err_buf, 2'b01);
        step();
        check_val("t3_dv", bus_a.datavalid, 0);
        bus_a.buf_rd = 1; bus_a.err_clr = 1; step();
        check_val("t3_clr_race", bus_a.err_buf, 2'b01);
        bus_a.err_clr = 1; step();
        check_val("t3_clr", bus_a.err_buf, 2'b00);

        // Steady count of 5 with simultaneous traffic long enough to wrap the pointers.
        for (int i = 0; i < 5; i++) begin
            bus_a.buf_wr = 1; bus_a.indata = 32'h2000 + i; step();
        end
        for (int i = 0; i < 1030; i++) begin
            bus_a.buf_wr = 1; bus_a.buf_rd = 1; bus_a.indata = 32'h3000 + i; step();
        end
        check_val("t4_wcount", bus_a.wcount, 5);
        for (int i = 0; i < 5; i++) begin
            bus_a.buf_rd = 1; step();
        end
        step();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            bus_a.buf_wr = 1'($urandom_range(0, 1)); bus_a.buf_rd = 1'($urandom_range(0, 1));
            bus_a.err_clr = ($urandom_range(0, 15) == 0); bus_a.indata = $urandom;
            bus_b.buf_wr = 1'($urandom_range(0, 1)); bus_b.buf_rd = 1'($urandom_range(0, 1));
            bus_b.err_clr = ($urandom_range(0, 15) == 0); bus_b.indata = $urandom;
            step();
        end
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (m_cnt_a == 0 && m_cnt_b == 0) break;
            bus_a.buf_rd = (m_cnt_a != 0); bus_b.buf_rd = (m_cnt_b != 0); step();
        end
        check_val("drain_a", bus_a.wcount, 0);
        check_val("drain_b", bus_b.wcount, 0);
        step();

        // Flush with a write pending: count clears, error history and output stay.
        bus_a.err_clr = 1; step();
        bus_a.buf_rd = 1; step();
        for (int i = 0; i < 7; i++) begin
            bus_a.buf_wr = 1; bus_a.indata = 32'h4000 + i; step();
        end
        check_val("t6_wcount7", bus_a.wcount, 7);
        saved = bus_a.outdata;
        bus_a.init = 1; bus_a.buf_wr = 1; bus_a.indata = 32'hBEEF; step();
        check_val("t6_wcount", bus_a.wcount, 0);
        check_val("t6_empty", bus_a.empty, 1);
        check_val("t6_err", bus_a.err_buf, 2'b01);
        check_val("t6_outdata", bus_a.outdata, saved);
        step();
        check_val("t6_err_after", bus_a.err_buf, 2'b01);

        // FWFT: single word latency and acknowledge.
        do_reset();
        bus_b.buf_wr = 1; bus_b.indata = 32'hA5; step();
        check_val("t5_dv_c1", bus_b.datavalid, 0);
        step();
        check_val("t5_dv_c2", bus_b.datavalid, 1);
        check_val("t5_data", bus_b.outdata, 32'hA5);
        bus_b.buf_rd = 1; step();
        check_val("t5_dv_off", bus_b.datavalid, 0);
        check_val("t5_wcount", bus_b.wcount, 0);

        // FWFT burst: back-to-back acknowledges keep DATAVALID high.
        for (int i = 0; i < 12; i++) begin
            bus_b.buf_wr = 1; bus_b.indata = 32'h5000 + i; step();
        end
        step();
        for (int i = 0; i < 12; i++) begin
            bus_b.buf_rd = 1; step();
        end
        check_val("t5_burst_empty", bus_b.empty, 1);

        // FWFT flush while a word is presented.
        for (int i = 0; i < 3; i++) begin
            bus_b.buf_wr = 1; bus_b.indata = 32'h6000 + i; step();
        end
        step();
        saved = bus_b.outdata;
        bus_b.init = 1; bus_b.buf_rd = 1; step();
        check_val("t5_init_dv", bus_b.datavalid, 0);
        check_val("t5_init_wcount", bus_b.wcount, 0);
        check_val("t5_init_outdata", bus_b.outdata, saved);
        step();
        step();

        check_val("a_sb_left", sb_a.size(), 0);
        check_val("b_sb_left", sb_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
